// File: rtl/bkadder_arb_pkg.sv
// -----------------------------------------------------------------------------
// bkadder_arb_pkg
//   Shared definitions for the dual-core adder arbiter:
//     - arb_state_t : FSM state encoding (IDLE, LO, HI, RESP)
//     - CORE0/CORE1 : requester identifiers, also the round-robin pointer values
//     - pick_winner : round-robin choice between the two request lines
// -----------------------------------------------------------------------------
package bkadder_arb_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LO   = 2'd1,
      HI   = 2'd2,
      RESP = 2'd3
   } arb_state_t;

   localparam logic CORE0 = 1'b0;
   localparam logic CORE1 = 1'b1;

   // A lone requester always wins; on a tie the pointer decides.
   function automatic logic pick_winner(input logic i_req0,
                                        input logic i_req1,
                                        input logic i_ptr);
      logic w_win;
      if (i_req0 && i_req1) w_win = i_ptr;
      else if (i_req1)      w_win = CORE1;
      else                  w_win = CORE0;
      return w_win;
   endfunction

endpackage

// File: rtl/bkadder_arbiter_bkadder.sv
// -----------------------------------------------------------------------------
// bkadder
//   Combinational N-bit Brent-Kung adder (N a power of two, N >= 4).
//   Ports:
//     i_a, i_b  [N-1:0]  operands
//     i_cin              carry-in
//     o_y       [N-1:0]  sum modulo 2^N
//     o_cout             carry-out of bit N-1
//   The prefix tree is expressed as whole-vector operations: each level
//   combines the positions selected by a constant stride mask with the
//   position 'dist' bits below it. The masks fold to constants, so only the
//   Brent-Kung black cells remain after synthesis.
// -----------------------------------------------------------------------------
module bkadder #(
   parameter int N = 32
) (
   input  logic [N-1:0] i_a,
   input  logic [N-1:0] i_b,
   input  logic         i_cin,
   output logic [N-1:0] o_y,
   output logic         o_cout
);

   localparam int          LEVELS = $clog2(N);
   localparam logic [N-1:0] ONE   = {{(N-1){1'b0}}, 1'b1};

   // Bits first, first+stride, first+2*stride, ... set.
   function automatic logic [N-1:0] stride_mask(input int first, input int stride);
      logic [N-1:0] m;
      m = '0;
      for (int k = first; k < N; k += stride) m = m | (ONE << k);
      return m;
   endfunction

   logic [N-1:0] w_p;    // per-bit propagate (also the half sum)
   logic [N-1:0] w_g;    // group generate, ends as carry out of each bit
   logic [N-1:0] w_gp;   // group propagate during the up-sweep

   always_comb begin
      // NOTE: every variable of this block is assigned before any branch or
      // loop touches it, so no path leaves a stale value and no latch appears.
      w_p  = i_a ^ i_b;
      // Carry-in is folded into bit 0 so the tree needs no extra column.
      w_g  = (i_a & i_b) | {{(N-1){1'b0}}, w_p[0] & i_cin};
      w_gp = w_p;

      // Up-sweep: positions with 'l+1' trailing ones absorb the span below.
      for (int l = 0; l < LEVELS; l++) begin
         w_g  = w_g | (stride_mask(2*(1 << l) - 1, 2*(1 << l)) & w_gp & (w_g << (1 << l)));
         w_gp = (w_gp & ~stride_mask(2*(1 << l) - 1, 2*(1 << l)))
              | (stride_mask(2*(1 << l) - 1, 2*(1 << l)) & w_gp & (w_gp << (1 << l)));
      end

      // Down-sweep: fill the positions between the completed prefixes.
      for (int l = LEVELS - 2; l >= 0; l--) begin
         w_g = w_g | (stride_mask(3*(1 << l) - 1, 2*(1 << l)) & w_gp & (w_g << (1 << l)));
      end
   end

   assign o_y    = w_p ^ {w_g[N-2:0], i_cin};
   assign o_cout = w_g[N-1];

endmodule

// File: rtl/bkadder_arbiter.sv
// -----------------------------------------------------------------------------
// bkadder_arbiter
//   Shares one N-bit Brent-Kung adder between two cores with round-robin
//   arbitration. Narrow requests take one adder pass; wide (2N-bit) requests
//   take a low pass then a high pass, carrying between them in r_carry.
//   Ports (per core k = 0,1):
//     reqk   request, held until gntk
//     widek  1 = 2N-bit add, 0 = N-bit add
//     ak, bk [2N-1:0] operands (only [N-1:0] used when narrow)
//     cink   carry-in
//     gntk   one-cycle pulse, operands captured on this cycle's edge
//     donek  one-cycle pulse, y/cout valid
//   Shared outputs:
//     y [2N-1:0]  registered sum
//     cout        registered final carry-out
//     busy        high in every state except IDLE
//   Reset (rst) is synchronous, active-high.
// -----------------------------------------------------------------------------
module bkadder_arbiter #(
   parameter int N = 32
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           req0,
   input  logic           wide0,
   input  logic [2*N-1:0] a0,
   input  logic [2*N-1:0] b0,
   input  logic           cin0,
   output logic           gnt0,
   output logic           done0,
   input  logic           req1,
   input  logic           wide1,
   input  logic [2*N-1:0] a1,
   input  logic [2*N-1:0] b1,
   input  logic           cin1,
   output logic           gnt1,
   output logic           done1,
   output logic [2*N-1:0] y,
   output logic           cout,
   output logic           busy
);

   import bkadder_arb_pkg::*;

   arb_state_t     r_state;
   arb_state_t     w_next_state;
   logic           r_ptr;      // core that wins the next tie
   logic           r_id;       // core being served
   logic           r_wide;
   logic           r_cin;
   logic           r_carry;    // low-pass carry feeding the high pass
   logic           r_cout;
   logic [2*N-1:0] r_a;
   logic [2*N-1:0] r_b;
   logic [2*N-1:0] r_y;

   logic           w_winner;
   logic           w_grant;
   logic [N-1:0]   w_add_a;
   logic [N-1:0]   w_add_b;
   logic           w_add_cin;
   logic [N-1:0]   w_add_y;
   logic           w_add_cout;

   assign w_winner = pick_winner(req0, req1, r_ptr);

   // ---------------------------------------------------------------------------
   // Next state, grant and adder operand mux
   // ---------------------------------------------------------------------------
   always_comb begin
      w_next_state = r_state;
      w_grant      = 1'b0;
      w_add_a      = r_a[N-1:0];
      w_add_b      = r_b[N-1:0];
      w_add_cin    = r_cin;
      case (r_state)
         IDLE: begin
            if (req0 || req1) begin
               w_grant      = 1'b1;
               w_next_state = LO;
            end
         end
         LO: begin
            w_next_state = r_wide ? HI : RESP;
         end
         HI: begin
            w_add_a      = r_a[2*N-1:N];
            w_add_b      = r_b[2*N-1:N];
            w_add_cin    = r_carry;
            w_next_state = RESP;
         end
         RESP: begin
            w_next_state = IDLE;
         end
         default: begin
            w_next_state = IDLE;
         end
      endcase
   end

   bkadder #(
      .N (N)
   ) u_bkadder (
      .i_a    (w_add_a),
      .i_b    (w_add_b),
      .i_cin  (w_add_cin),
      .o_y    (w_add_y),
      .o_cout (w_add_cout)
   );

   // ---------------------------------------------------------------------------
   // Control state and result registers
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments here so every register samples the
      // values from before this edge, independent of statement order.
      if (rst) begin
         r_state <= IDLE;
         r_ptr   <= CORE0;
         r_carry <= 1'b0;
         r_cout  <= 1'b0;
         r_y     <= '0;
      end else begin
         r_state <= w_next_state;
         case (r_state)
            LO: begin
               // Upper half cleared here; a wide op overwrites it in HI.
               r_y     <= {{N{1'b0}}, w_add_y};
               r_carry <= w_add_cout;
               r_cout  <= w_add_cout;
            end
            HI: begin
               r_y[2*N-1:N] <= w_add_y;
               r_cout       <= w_add_cout;
            end
            RESP: begin
               r_ptr <= ~r_id;
            end
            default: begin
            end
         endcase
      end
   end

   // ---------------------------------------------------------------------------
   // Operand capture on the grant edge
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      // NOTE: these capture registers carry no reset: they are only read in
      // LO/HI/RESP, and every path into those states passes a grant that
      // loads them first.
      if (w_grant) begin
         r_id   <= w_winner;
         r_a    <= (w_winner == CORE1) ? a1    : a0;
         r_b    <= (w_winner == CORE1) ? b1    : b0;
         r_cin  <= (w_winner == CORE1) ? cin1  : cin0;
         r_wide <= (w_winner == CORE1) ? wide1 : wide0;
      end
   end

   assign gnt0  = w_grant && (w_winner == CORE0);
   assign gnt1  = w_grant && (w_winner == CORE1);
   assign done0 = (r_state == RESP) && (r_id == CORE0);
   assign done1 = (r_state == RESP) && (r_id == CORE1);
   assign y     = r_y;
   assign cout  = r_cout;
   assign busy  = (r_state != IDLE);

endmodule

// File: tb/tb_bkadder_arbiter.sv
// -----------------------------------------------------------------------------
// tb_bkadder_arbiter
//   Directed vectors with hand-computed sums for the shared-adder arbiter.
//   Inputs change 1 time unit after a rising edge; outputs are sampled on the
//   falling edge. 'cyc' counts rising edges so grant-to-done latency can be
//   measured in cycles.
// -----------------------------------------------------------------------------
module tb_bkadder_arbiter;

   localparam int N = 32;

   logic           clk = 1'b0;
   logic           rst;
   logic           req0, wide0, cin0, req1, wide1, cin1;
   logic [2*N-1:0] a0, b0, a1, b1;
   logic           gnt0, gnt1, done0, done1, cout, busy;
   logic [2*N-1:0] y;

   int vectors     = 0;
   int miscompares = 0;
   int cyc         = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   bkadder_arbiter #(.N(N)) dut (
      .clk   (clk),
      .rst   (rst),
      .req0  (req0),
      .wide0 (wide0),
      .a0    (a0),
      .b0    (b0),
      .cin0  (cin0),
      .gnt0  (gnt0),
      .done0 (done0),
      .req1  (req1),
      .wide1 (wide1),
      .a1    (a1),
      .b1    (b1),
      .cin1  (cin1),
      .gnt1  (gnt1),
      .done1 (done1),
      .y     (y),
      .cout  (cout),
      .busy  (busy)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%h, expected 0x%h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic start_req(input int core, input logic w, input logic [63:0] a,
                            input logic [63:0] b, input logic c);
      if (core == 0) begin
         wide0 = w; a0 = a; b0 = b; cin0 = c; req0 = 1'b1;
      end else begin
         wide1 = w; a1 = a; b1 = b; cin1 = c; req1 = 1'b1;
      end
   endtask

   task automatic drop_req(input int core);
      if (core == 0) req0 = 1'b0;
      else           req1 = 1'b0;
   endtask

   // Waits (bounded) for the grant of 'core'; returns the grant cycle.
   task automatic wait_gnt(input string tag, input int core, output int t);
      logic got;
      got = 1'b0;
      t   = -1;
      for (int k = 0; k < 20 && !got; k++) begin
         @(negedge clk);
         if ((core == 0) ? gnt0 : gnt1) begin
            got = 1'b1;
            t   = cyc;
            check({tag, "_gnt_excl"}, 64'((core == 0) ? gnt1 : gnt0), 64'd0);
         end
      end
      check({tag, "_gnt_seen"}, 64'(got), 64'd1);
   endtask

   // Waits (bounded) for done of 'core' and checks latency and result.
   task automatic wait_done(input string tag, input int core, input int t, input int lat,
                            input logic [63:0] ey, input logic ec);
      logic seen;
      seen = 1'b0;
      for (int k = 0; k < 10 && !seen; k++) begin
         @(negedge clk);
         if ((core == 0) ? done0 : done1) begin
            seen = 1'b1;
            check({tag, "_lat"},       64'(cyc - t), 64'(lat));
            check({tag, "_y"},         y, ey);
            check({tag, "_cout"},      64'(cout), 64'(ec));
            check({tag, "_done_excl"}, 64'((core == 0) ? done1 : done0), 64'd0);
         end
      end
      check({tag, "_done_seen"}, 64'(seen), 64'd1);
   endtask

   task automatic do_op(input string tag, input int core, input logic w,
                        input logic [63:0] a, input logic [63:0] b, input logic c,
                        input logic [63:0] ey, input logic ec);
      int t;
      @(posedge clk); #1;
      start_req(core, w, a, b, c);
      wait_gnt(tag, core, t);
      @(posedge clk); #1;
      drop_req(core);
      wait_done(tag, core, t, w ? 3 : 2, ey, ec);
   endtask

   task automatic apply_reset();
      @(posedge clk); #1;
      rst  = 1'b1;
      req0 = 1'b0;
      req1 = 1'b0;
      @(posedge clk); #1;
      rst  = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int t;
      int grants;
      int last_core;

      rst = 1'b1;
      req0 = 1'b0; wide0 = 1'b0; a0 = '0; b0 = '0; cin0 = 1'b0;
      req1 = 1'b0; wide1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0;

      // Reset state
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_gnt",  64'({gnt0, gnt1}),   64'd0);
      check("rst_done", 64'({done0, done1}), 64'd0);
      check("rst_y",    y,                   64'd0);
      check("rst_cout", 64'(cout),           64'd0);
      check("rst_busy", 64'(busy),           64'd0);
      @(posedge clk); #1;
      rst = 1'b0;

      // Single-core operations
      do_op("narrow", 0, 1'b0, 64'h0A, 64'h0B, 1'b0, 64'h0000000000000015, 1'b0);
      do_op("wide_carry", 1, 1'b1, 64'h00000000_FFFFFFFF, 64'h1, 1'b0,
            64'h00000001_00000000, 1'b0);
      do_op("wide_ovf", 0, 1'b1, 64'hFFFFFFFF_FFFFFFFF, 64'h0, 1'b1,
            64'h0, 1'b1);

      // Tie and fairness: both held, four grants must alternate 0,1,0,1
      apply_reset();
      start_req(0, 1'b0, 64'h12345678, 64'h87654321, 1'b1);
      start_req(1, 1'b0, 64'hAAAAAAAA, 64'h55555555, 1'b0);
      grants    = 0;
      last_core = -1;
      t         = -1;
      for (int k = 0; k < 40 && grants < 4; k++) begin
         @(negedge clk);
         if (done0 || done1) begin
            check("tie_done_core", 64'({done0, done1}), (last_core == 0) ? 64'd2 : 64'd1);
            check("tie_y", y, (last_core == 0) ? 64'h9999999A : 64'hFFFFFFFF);
         end
         if (gnt0 || gnt1) begin
            check("tie_order", 64'({gnt0, gnt1}), (grants % 2 == 0) ? 64'd2 : 64'd1);
            last_core = gnt1 ? 1 : 0;
            grants++;
            t = cyc;
         end
      end
      check("tie_grants", 64'(grants), 64'd4);
      @(posedge clk); #1;
      drop_req(0);
      drop_req(1);
      wait_done("tie_last", 1, t, 2, 64'hFFFFFFFF, 1'b0);

      // Narrow wrap: moves the pointer to core1 before the reset test
      do_op("narrow_wrap", 0, 1'b0, 64'hFFFFFFFF, 64'h1, 1'b0, 64'h0, 1'b1);

      // Reset during HI
      @(posedge clk); #1;
      start_req(1, 1'b1, 64'h00000005_FFFFFFFF, 64'h00000003_00000009, 1'b0);
      wait_gnt("rst_hi", 1, t);
      @(posedge clk); #1;                // LO cycle
      drop_req(1);
      @(posedge clk); #1;                // HI cycle
      @(negedge clk);
      check("rst_hi_busy",   64'(busy), 64'd1);
      check("rst_hi_y_lo",   y,         64'h00000000_00000008);
      check("rst_hi_cout_lo", 64'(cout), 64'd1);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      check("rst_hi_after_y",    y,                   64'd0);
      check("rst_hi_after_cout", 64'(cout),           64'd0);
      check("rst_hi_after_busy", 64'(busy),           64'd0);
      check("rst_hi_after_done", 64'({done0, done1}), 64'd0);
      repeat (5) begin
         @(negedge clk);
         check("rst_hi_no_done", 64'({done0, done1}), 64'd0);
      end

      // Pointer back at core0 after reset
      @(posedge clk); #1;
      start_req(0, 1'b0, 64'h12345678, 64'h87654321, 1'b1);
      start_req(1, 1'b0, 64'hAAAAAAAA, 64'h55555555, 1'b0);
      wait_gnt("post_rst_tie", 0, t);
      @(posedge clk); #1;
      drop_req(0);
      drop_req(1);
      wait_done("post_rst_tie", 0, t, 2, 64'h9999999A, 1'b0);

      // Operand change after grant; req0 stays high for a second op
      @(posedge clk); #1;
      start_req(0, 1'b0, 64'h10, 64'h20, 1'b0);
      wait_gnt("opchg", 0, t);
      @(posedge clk); #1;                // T+1
      a0 = 64'hFFFFFFFF;
      @(negedge clk);
      check("opchg_no_gnt_t1", 64'(gnt0), 64'd0);
      @(negedge clk);                    // T+2: RESP
      check("opchg_no_gnt_t2", 64'(gnt0),   64'd0);
      check("opchg_done",      64'(done0),  64'd1);
      check("opchg_lat",       64'(cyc - t), 64'd2);
      check("opchg_y",         y,           64'h30);
      @(negedge clk);                    // T+3: IDLE, fresh grant
      check("opchg_regnt", 64'(gnt0), 64'd1);
      t = cyc;
      @(posedge clk); #1;
      drop_req(0);
      wait_done("opchg_second", 0, t, 2, 64'h1F, 1'b1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/bkadder_arbiter.md
Name: bkadder_arbiter

Overview:
- Shares one bkadder instance (N-bit Brent-Kung adder: A, B, Cin -> Y, Cout) between the two cores of the dual-core processor.
- Round-robin arbitration with a req/gnt/done handshake per core.
- Each request is either narrow (N-bit) or wide (2N-bit).
- A wide request is sequenced as two adder passes, low half then high half, with the carry held in a register between passes.

Parameters:
- N, 32, width of the shared adder; wide operands are 2N bits.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- req0  in  1  core0 request; held high until gnt0
- wide0  in  1  core0 op size; 1 = 2N-bit add, 0 = N-bit add
- a0  in  2N  core0 operand A; only [N-1:0] used when narrow
- b0  in  2N  core0 operand B
- cin0  in  1  core0 carry-in
- gnt0  out  1  one-cycle pulse; core0 operands captured this cycle
- done0  out  1  one-cycle pulse; y/cout valid for core0
- req1, wide1, a1, b1, cin1, gnt1, done1: same as core0 ports, for core1
- y  out  2N  registered sum; valid while done0 or done1 is high
- cout  out  1  registered final carry-out
- busy  out  1  high in every state except IDLE

Behaviour:
- Clock and reset: one clock (clk); reset (rst) is synchronous and active-high.
- Reset values: state=IDLE, gnt0=gnt1=0, done0=done1=0, y=0, cout=0, busy=0, carry register=0, priority pointer=core0.
- FSM states: IDLE, LO, HI, RESP.
- IDLE, with no req: stay in IDLE.
- IDLE, with at least one req:
  - choose a winner; assert gnt for the winner (combinational, this cycle only);
  - on the clock edge, capture a, b, cin, wide and the winner id; go to LO.
- Arbitration:
  - only one req high: that core wins;
  - both high: the core the pointer names wins;
  - the pointer moves to the other core when its RESP completes.
  - After reset, core0 wins the first tie.
- LO:
  - adder inputs: A=a_q[N-1:0], B=b_q[N-1:0], Cin=cin_q;
  - register the sum into y[N-1:0] and the carry into carry_q;
  - if wide_q go to HI, else go to RESP.
  - Narrow ops: y[2N-1:N]=0 and cout=low-pass carry.
- HI:
  - adder inputs: A=a_q[2N-1:N], B=b_q[2N-1:N], Cin=carry_q;
  - register the sum into y[2N-1:N] and the carry into cout; go to RESP.
- RESP:
  - done of the stored winner = 1 for exactly one cycle;
  - y/cout hold their values until the next operation's LO pass writes them;
  - go to IDLE and update the pointer.
- No grant is issued in RESP.
- Latency, with grant in cycle T:
  - narrow: done in T+2;
  - wide: done in T+3.
- Fastest next grant is T+3 (narrow) or T+4 (wide).
- gnt0 and gnt1 are never high together; done0 and done1 are never high together.
- Only one request is in flight; requests that lose stay pending. The block does not queue.
- Operands and wide are sampled only on the gnt edge. Changing them later has no effect on the operation in flight.
- A req that drops before gnt is dropped silently; no done is issued.
- Reset mid-operation (any state):
  - abort; no done;
  - outputs return to reset values next cycle;
  - the pointer returns to core0.
- Wrap-around: the sum is modulo 2^N (narrow) or 2^2N (wide); overflow shows only in cout.

Decomposition:
- Shared package (bkadder_arb_pkg):
  - state encoding constants: IDLE=2'd0, LO=2'd1, HI=2'd2, RESP=2'd3;
  - requester id constants: CORE0=1'b0, CORE1=1'b1.
- One sub-module: the existing bkadder with N as its width, instantiated once.
- Operand mux, carry register and FSM stay in bkadder_arbiter. Do not build a separate adder.

Test Plan:
- Narrow add: core0 only, a0=0x0A, b0=0x0B, cin0=0, wide0=0 -> gnt0 at T, done0 at T+2, y=0x0000000000000015, cout=0.
- Wide carry across halves: core1, a1=0x00000000_FFFFFFFF, b1=0x1, cin1=0, wide1=1 -> done1 at T+3, y=0x00000001_00000000, cout=0.
- Wide overflow: core0, a0=0xFFFFFFFF_FFFFFFFF, b0=0, cin0=1, wide0=1 -> y=0, cout=1, done0 at T+3.
- Tie and fairness:
  - setup: after reset, req0 and req1 both held, narrow; core0 adds 0x12345678+0x87654321 (cin0=1), core1 adds 0xAAAAAAAA+0x55555555 (cin1=0);
  - required: core0 granted first, done0 with y=0x9999999A; then core1 granted, done1 with y=0xFFFFFFFF;
  - grants strictly alternate while both stay held.
- Reset during HI: wide op with rst=1 in the HI cycle -> no done in any later cycle, y=0, cout=0, busy=0 next cycle; next tie grants core0.
- Operand change after grant: change a0 to 0xFFFFFFFF in cycle T+1 -> result uses the value captured at T; no second gnt0 until RESP completes.
